// File: rtl/prog_clk_divider_if.sv
// prog_clk_divider_if: control and status bundle of the programmable clock divider
interface prog_clk_divider_if #(
    parameter int DIV_WIDTH = 8
);
    logic                 en;
    logic                 load;
    logic [DIV_WIDTH-1:0] div;
    logic                 out;
    logic                 tick;
    logic                 pending;
    logic [DIV_WIDTH-1:0] active_div;

    modport master (
        output en, load, div,
        input  out, tick, pending, active_div
    );

    modport slave (
        input  en, load, div,
        output out, tick, pending, active_div
    );
endinterface

// File: rtl/prog_clk_divider.sv
// prog_clk_divider: runtime-programmable integer divider, near-50% duty, glitch-free ratio changes
module prog_clk_divider #(
    parameter int DIV_WIDTH   = 8,
    parameter int DEFAULT_DIV = 4
) (
    input  logic               in,
    input  logic               rst_n,
    prog_clk_divider_if.slave  bus
);
    typedef logic [DIV_WIDTH-1:0] div_t;
    typedef logic [DIV_WIDTH:0]   half_t;

    div_t  cnt_q, cnt_d;
    div_t  div_q, div_d;
    div_t  pend_div_q, pend_div_d;
    div_t  div_clamped;
    logic  pending_q, pending_d;
    logic  out_q, out_d;
    logic  tick_q, tick_d;
    logic  boundary;
    half_t half;

    assign div_clamped = (bus.div < div_t'(2)) ? div_t'(2) : bus.div;
    assign boundary    = bus.en && (cnt_q == div_q - div_t'(1));

    // Next state: ratio swaps only at a period boundary; half uses the post-edge ratio
    always_comb begin
        div_d      = div_q;
        pend_div_d = pend_div_q;
        pending_d  = pending_q;
        if (bus.load && !boundary) begin
            pend_div_d = div_clamped;
            pending_d  = 1'b1;
        end
        if (boundary) begin
            cnt_d     = '0;
            pending_d = 1'b0;
            div_d     = bus.load ? div_clamped : (pending_q ? pend_div_q : div_q);
        end else begin
            cnt_d = bus.en ? cnt_q + div_t'(1) : div_q - div_t'(1);
        end
        half   = (half_t'(div_d) + half_t'(1)) >> 1;
        out_d  = bus.en && (half_t'(cnt_d) < half);
        tick_d = bus.en && (cnt_d == '0);
    end

    // State register with synchronous active-low reset that truncates the current period
    always_ff @(posedge in) begin
        if (!rst_n) begin
            cnt_q      <= div_t'(DEFAULT_DIV - 1);
            div_q      <= div_t'(DEFAULT_DIV);
            pend_div_q <= '0;
            pending_q  <= 1'b0;
            out_q      <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            pend_div_q <= pend_div_d;
            pending_q  <= pending_d;
            out_q      <= out_d;
            tick_q     <= tick_d;
        end
    end

    assign bus.out        = out_q;
    assign bus.tick       = tick_q;
    assign bus.pending    = pending_q;
    assign bus.active_div = div_q;
endmodule

// File: tb/tb_prog_clk_divider.sv
// tb_prog_clk_divider: directed and random checks against a period-waveform reference model
module tb_prog_clk_divider;
    localparam int W   = 4;
    localparam int DEF = 4;

    logic in = 1'b0;
    logic rst_n = 1'b0;

    prog_clk_divider_if #(.DIV_WIDTH(W)) bus ();

    prog_clk_divider #(.DIV_WIDTH(W), .DEFAULT_DIV(DEF)) dut (
        .in    (in),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 in = ~in;

    int compared = 0;
    int mismatched = 0;

    // Reference model: each output period is generated whole as a queue of levels
    int m_d = DEF;
    int m_pv = 0;
    bit m_pend = 0;
    bit m_out = 0;
    bit m_tick = 0;
    bit q[$];

    function automatic int clampv(int v);
        return (v < 2) ? 2 : v;
    endfunction

    task automatic check(string tag, logic [7:0] obs, logic [7:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model(bit r, bit e, bit l, int dv);
        if (!r) begin
            m_d = DEF;
            m_pend = 0;
            q.delete();
            m_out = 0;
            m_tick = 0;
        end else if (!e) begin
            q.delete();
            m_out = 0;
            m_tick = 0;
            if (l) begin
                m_pv = clampv(dv);
                m_pend = 1;
            end
        end else begin
            if (q.size() == 0) begin
                if (l) begin
                    m_d = clampv(dv);
                    m_pend = 0;
                end else if (m_pend) begin
                    m_d = m_pv;
                    m_pend = 0;
                end
                for (int i = 0; i < m_d; i++) q.push_back(i < (m_d + 1) / 2);
                m_tick = 1;
            end else begin
                m_tick = 0;
                if (l) begin
                    m_pv = clampv(dv);
                    m_pend = 1;
                end
            end
            m_out = q.pop_front();
        end
    endtask

    task automatic step(bit r, bit e, bit l, int dv);
        int dvt;
        dvt = dv % (1 << W);
        rst_n    = r;
        bus.en   = e;
        bus.load = l;
        bus.div  = dvt[W-1:0];
        @(posedge in);
        #1;
        model(r, e, l, dvt);
        check("out", 8'(bus.out), 8'(m_out));
        check("tick", 8'(bus.tick), 8'(m_tick));
        check("pending", 8'(bus.pending), 8'(m_pend));
        check("active_div", 8'(bus.active_div), 8'(m_d));
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) step(1, 1, 0, 0);
    endtask

    task automatic run_to_boundary();
        for (int i = 0; i < 40 && q.size() != 0; i++) step(1, 1, 0, 0);
    endtask

    initial begin
        bus.en = 1'b0;
        bus.load = 1'b0;
        bus.div = '0;
        step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        run(12);
        step(1, 1, 0, 0);
        step(1, 1, 1, 5);
        run(12);
        step(1, 1, 1, 3);
        run(8);
        step(1, 1, 1, 2);
        run(6);
        step(1, 1, 1, 15);
        run(32);
        step(1, 1, 1, 0);
        run(6);
        step(1, 1, 1, 1);
        run(6);
        step(1, 1, 1, 15);
        run_to_boundary();
        run(3);
        step(1, 1, 1, 7);
        step(1, 1, 1, 9);
        run(20);
        run_to_boundary();
        step(1, 1, 1, 6);
        run(8);
        run_to_boundary();
        step(1, 1, 0, 0);
        step(1, 0, 0, 0);
        step(1, 0, 1, 3);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(1, 1, 0, 0);
        run(9);
        run_to_boundary();
        step(1, 1, 0, 0);
        step(1, 1, 1, 5);
        step(0, 1, 0, 0);
        run(10);
        for (int i = 0; i < 500; i++)
            step($urandom_range(0, 49) != 0, $urandom_range(0, 9) != 0,
                 $urandom_range(0, 5) == 0, int'($urandom_range(0, 15)));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
